// File: rtl/mux_pkg.sv
// Shared definitions for the streaming multiplexer family.
package mux_pkg;

  // Source selection mode for stream_mux_rr.
  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // Ceiling log2 for sizing index fields; returns at least 1 so a
  // two-channel mux still gets a one-bit select.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first asserted request at or after base,
// wrapping from N-1 back to 0.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] base,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Walk the priority order backwards so the last hit written is the
  // highest-priority one; no early exit needed.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = int'(base) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with a registered output stage.
// Channel is chosen either by sel or by round-robin among valid inputs.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 1,
  localparam int SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_idx;
  logic          rr_any;
  logic [SW-1:0] gnt_idx;
  logic          gnt_any;
  logic          ld;
  logic          xfer;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (in_valid),
    .base    (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Output register can accept a word when empty or draining this cycle.
  assign ld   = !out_valid || out_ready;
  assign xfer = gnt_any && ld && !rst;

  // Mode mux: explicit select (out-of-range sel never matches) or round-robin.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (mode == MODE_RR) begin
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (sel == SW'(k) && in_valid[k]) begin
          gnt_idx = sel;
          gnt_any = 1'b1;
        end
      end
    end
  end

  // Only the granted channel sees ready, and only when the register can load.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (ld) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(gnt_idx)*W +: W];
        out_chan  <= gnt_idx;
        if (mode == MODE_RR) begin
          ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr with N=4, W=8.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_ready;

  int n_cmp;
  int n_bad;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus: inputs, ready expected before the edge,
  // register contents expected after it.
  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] iv,
                     input logic [31:0] d, input logic ordy, input logic [3:0] er,
                     input logic ev, input logic [7:0] ed, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.mode = m; v.sel = s; v.in_valid = iv; v.in_data = d;
    v.out_ready = ordy; v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_chan = ec;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] D  = 32'hD3C2B1A0;  // ch0=A0 ch1=B1 ch2=C2 ch3=D3
  localparam logic [31:0] DA = 32'hD3A5B1A0;  // ch2=A5

  initial begin
    logic [3:0] one_hot;
    logic [7:0] exp_byte;
    logic [31:0] dword;

    n_cmp = 0;
    n_bad = 0;

    //   rst mode sel  valid   data ordy ready  ov  data   chan
    // Reset held two cycles with all inputs valid.
    add(1, 1, 0, 4'b1111, D,  1, 4'b0000, 0, 8'h00, 0);
    add(1, 1, 0, 4'b1111, D,  1, 4'b0000, 0, 8'h00, 0);
    // Select mode: ch2 carries A5; then sel=3 with ch3 idle -> bubble, data held.
    add(0, 0, 2, 4'b0100, DA, 1, 4'b0100, 1, 8'hA5, 2);
    add(0, 0, 3, 4'b0100, DA, 1, 4'b0000, 0, 8'hA5, 2);
    // Round-robin, all valid, 8 back-to-back grants 0..3,0..3 (ptr starts 0).
    add(0, 1, 0, 4'b1111, D,  1, 4'b0001, 1, 8'hA0, 0);
    add(0, 1, 0, 4'b1111, D,  1, 4'b0010, 1, 8'hB1, 1);
    add(0, 1, 0, 4'b1111, D,  1, 4'b0100, 1, 8'hC2, 2);
    add(0, 1, 0, 4'b1111, D,  1, 4'b1000, 1, 8'hD3, 3);
    add(0, 1, 0, 4'b1111, D,  1, 4'b0001, 1, 8'hA0, 0);
    add(0, 1, 0, 4'b1111, D,  1, 4'b0010, 1, 8'hB1, 1);
    add(0, 1, 0, 4'b1111, D,  1, 4'b0100, 1, 8'hC2, 2);
    add(0, 1, 0, 4'b1111, D,  1, 4'b1000, 1, 8'hD3, 3);
    // Round-robin with only ch1, ch3 valid: 1,3,1,3.
    add(0, 1, 0, 4'b1010, D,  1, 4'b0010, 1, 8'hB1, 1);
    add(0, 1, 0, 4'b1010, D,  1, 4'b1000, 1, 8'hD3, 3);
    add(0, 1, 0, 4'b1010, D,  1, 4'b0010, 1, 8'hB1, 1);
    add(0, 1, 0, 4'b1010, D,  1, 4'b1000, 1, 8'hD3, 3);
    // Backpressure: D3/ch3 held three cycles, then drain+load on one edge.
    add(0, 1, 0, 4'b1111, D,  0, 4'b0000, 1, 8'hD3, 3);
    add(0, 1, 0, 4'b1111, D,  0, 4'b0000, 1, 8'hD3, 3);
    add(0, 1, 0, 4'b1111, D,  0, 4'b0000, 1, 8'hD3, 3);
    add(0, 1, 0, 4'b1111, D,  1, 4'b0001, 1, 8'hA0, 0);
    // Stall while changing mode/sel leaves the held word untouched.
    add(0, 0, 1, 4'b0010, D,  0, 4'b0000, 1, 8'hA0, 0);
    add(0, 0, 1, 4'b0010, D,  1, 4'b0010, 1, 8'hB1, 1);
    // Select-mode grant left ptr at 1.
    add(0, 1, 0, 4'b1111, D,  1, 4'b0010, 1, 8'hB1, 1);
    // Nothing valid: bubble, data/chan hold; ptr now 2.
    add(0, 1, 0, 4'b0000, D,  1, 4'b0000, 0, 8'hB1, 1);
    // Fill output via select mode (ptr stays 2), then reset mid-stream.
    add(0, 0, 1, 4'b0010, D,  1, 4'b0010, 1, 8'hB1, 1);
    add(1, 1, 0, 4'b1111, D,  1, 4'b0000, 0, 8'h00, 0);
    // First round-robin grant after reset is ch0.
    add(0, 1, 0, 4'b1111, D,  1, 4'b0001, 1, 8'hA0, 0);

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(vecs[i].exp_chan));
    end

    // Select-mode sweep: one valid channel at a time, each word must come
    // from that channel with a distinct payload.
    dword = 32'h44332211;
    for (int s = 0; s < N; s++) begin
      one_hot  = 4'(1 << s);
      exp_byte = 8'((s + 1) * 8'h11);
      rst       = 1'b0;
      mode      = 1'b0;
      sel       = 2'(s);
      in_valid  = one_hot;
      in_data   = dword;
      out_ready = 1'b1;
      #1;
      check($sformatf("sweep%0d in_ready", s), 32'(in_ready), 32'(one_hot));
      @(posedge clk);
      #1;
      check($sformatf("sweep%0d out_valid", s), 32'(out_valid), 32'd1);
      check($sformatf("sweep%0d out_data", s), 32'(out_data), 32'(exp_byte));
      check($sformatf("sweep%0d out_chan", s), 32'(out_chan), 32'(s));
    end

    // Round-robin picks up from ptr, which select mode left at 1 (set
    // by the last round-robin grant of ch0 before the sweep).
    mode     = 1'b1;
    in_valid = 4'b0101;
    #1;
    check("rr_after_sel in_ready", 32'(in_ready), 32'(4'b0100));
    @(posedge clk);
    #1;
    check("rr_after_sel out_chan", 32'(out_chan), 32'd2);
    check("rr_after_sel out_data", 32'(out_data), 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
